// File: rtl/bp_be_fe_queue_sink_pkg.sv
// Shared defaults and elaboration helpers for the BE-side FE queue sink.
package bp_be_fe_queue_sink_pkg;

  localparam int unsigned fe_queue_width_dp = 128;
  localparam int unsigned fe_cmd_width_dp   = 128;
  localparam int unsigned queue_els_dp      = 8;
  localparam int unsigned cmd_els_dp        = 2;

  // Depths index with the low pointer bits, so they must be powers of two.
  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_be_fe_cmd_fifo.sv
// Small valid/yumi FIFO carrying BE-generated commands toward the front end.
module bp_be_fe_cmd_fifo
  import bp_be_fe_queue_sink_pkg::*;
#(
  parameter int unsigned width_p = fe_cmd_width_dp,
  parameter int unsigned els_p   = cmd_els_dp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int unsigned lg_els_lp = $clog2(els_p);
  localparam int unsigned ptr_w_lp  = lg_els_lp + 1;

  logic [ptr_w_lp-1:0] wptr_r, rptr_r, count;
  logic [width_p-1:0]  mem_r [els_p];
  logic                push, pop;

  assign count   = wptr_r - rptr_r;
  assign ready_o = (count != ptr_w_lp'(els_p));
  assign v_o     = (count != '0);
  assign data_o  = mem_r[rptr_r[lg_els_lp-1:0]];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      wptr_r <= wptr_r + ptr_w_lp'(push);
      rptr_r <= rptr_r + ptr_w_lp'(pop);
    end
  end

  // Payload storage carries no reset; validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r[lg_els_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_be_fe_queue_sink.sv
// BE endpoint of the FE/BE interface: speculative FE queue with commit/roll/flush,
// plus a command FIFO back to the front end.
module bp_be_fe_queue_sink
  import bp_be_fe_queue_sink_pkg::*;
#(
  parameter int unsigned fe_queue_width_p = fe_queue_width_dp,
  parameter int unsigned fe_cmd_width_p   = fe_cmd_width_dp,
  parameter int unsigned queue_els_p      = queue_els_dp,
  parameter int unsigned cmd_els_p        = cmd_els_dp
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [fe_queue_width_p-1:0]       fe_queue_i,
  input  logic                              fe_queue_v_i,
  output logic                              fe_queue_ready_o,
  output logic [fe_queue_width_p-1:0]       issue_pkt_o,
  output logic                              issue_v_o,
  input  logic                              issue_yumi_i,
  input  logic                              commit_i,
  input  logic                              roll_i,
  input  logic                              clr_i,
  output logic [$clog2(queue_els_p):0]      occupancy_o,
  input  logic [fe_cmd_width_p-1:0]         cmd_i,
  input  logic                              cmd_v_i,
  output logic                              cmd_ready_o,
  output logic [fe_cmd_width_p-1:0]         fe_cmd_o,
  output logic                              fe_cmd_v_o,
  input  logic                              fe_cmd_yumi_i
);

  localparam int unsigned lg_els_lp = $clog2(queue_els_p);
  localparam int unsigned ptr_w_lp  = lg_els_lp + 1;

  logic [ptr_w_lp-1:0]         wptr_r, rptr_r, cptr_r;
  logic [ptr_w_lp-1:0]         wptr_n, rptr_n, cptr_n;
  logic [ptr_w_lp-1:0]         occ;
  logic [fe_queue_width_p-1:0] mem_r [queue_els_p];
  logic                        enq;

  // Outputs depend only on registered pointers.
  assign occ              = wptr_r - cptr_r;
  assign occupancy_o      = occ;
  assign fe_queue_ready_o = (occ != ptr_w_lp'(queue_els_p));
  assign issue_v_o        = (rptr_r != wptr_r);
  assign issue_pkt_o      = mem_r[rptr_r[lg_els_lp-1:0]];
  assign enq              = fe_queue_v_i & fe_queue_ready_o;

  // Flush beats commit/roll/yumi; a beat accepted alongside a flush is skipped over.
  always_comb begin
    wptr_n = wptr_r + ptr_w_lp'(enq);
    rptr_n = rptr_r;
    cptr_n = cptr_r;
    if (clr_i) begin
      rptr_n = wptr_n;
      cptr_n = wptr_n;
    end else begin
      if (commit_i && (cptr_r != rptr_r)) cptr_n = cptr_r + ptr_w_lp'(1);
      if (roll_i) rptr_n = cptr_n;
      else if (issue_yumi_i && issue_v_o) rptr_n = rptr_r + ptr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[lg_els_lp-1:0]] <= fe_queue_i;
  end

  // Command path is independent of clr_i so redirects survive the flush they cause.
  bp_be_fe_cmd_fifo #(
    .width_p (fe_cmd_width_p),
    .els_p   (cmd_els_p)
  ) cmd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (cmd_i),
    .v_i       (cmd_v_i),
    .ready_o   (cmd_ready_o),
    .data_o    (fe_cmd_o),
    .v_o       (fe_cmd_v_o),
    .yumi_i    (fe_cmd_yumi_i)
  );

  if (!is_pow2(queue_els_p)) begin : g_bad_queue_els
    $error("queue_els_p must be a power of 2 and at least 2");
  end
  if (!is_pow2(cmd_els_p)) begin : g_bad_cmd_els
    $error("cmd_els_p must be a power of 2 and at least 2");
  end

  a_cmd_yumi_has_v: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) fe_cmd_yumi_i |-> fe_cmd_v_o
  );

endmodule

// File: tb/tb_bp_be_fe_queue_sink.sv
// Directed bench for the FE queue sink: fill, replay, flush, full-commit, commands, mid-run reset.
module tb_bp_be_fe_queue_sink;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [127:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [127:0] issue_pkt_o;
  logic         issue_v_o;
  logic         issue_yumi_i;
  logic         commit_i;
  logic         roll_i;
  logic         clr_i;
  logic [3:0]   occupancy_o;
  logic [127:0] cmd_i;
  logic         cmd_v_i;
  logic         cmd_ready_o;
  logic [127:0] fe_cmd_o;
  logic         fe_cmd_v_o;
  logic         fe_cmd_yumi_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_be_fe_queue_sink #(
    .fe_queue_width_p (128),
    .fe_cmd_width_p   (128),
    .queue_els_p      (8),
    .cmd_els_p        (2)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .issue_pkt_o      (issue_pkt_o),
    .issue_v_o        (issue_v_o),
    .issue_yumi_i     (issue_yumi_i),
    .commit_i         (commit_i),
    .roll_i           (roll_i),
    .clr_i            (clr_i),
    .occupancy_o      (occupancy_o),
    .cmd_i            (cmd_i),
    .cmd_v_i          (cmd_v_i),
    .cmd_ready_o      (cmd_ready_o),
    .fe_cmd_o         (fe_cmd_o),
    .fe_cmd_v_o       (fe_cmd_v_o),
    .fe_cmd_yumi_i    (fe_cmd_yumi_i)
  );

  task automatic idle();
    fe_queue_i    = '0;
    fe_queue_v_i  = 1'b0;
    issue_yumi_i  = 1'b0;
    commit_i      = 1'b0;
    roll_i        = 1'b0;
    clr_i         = 1'b0;
    cmd_i         = '0;
    cmd_v_i       = 1'b0;
    fe_cmd_yumi_i = 1'b0;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n_i = 1'b0;
    #12;
    n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", fe_queue_ready_o); end
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
    n_cmp++; if (issue_v_o !== 1'b0) begin n_err++; $display("FAIL reset_issue_v: got %b want 0", issue_v_o); end
    n_cmp++; if (fe_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL reset_fe_cmd_v: got %b want 0", fe_cmd_v_o); end
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    reset_n_i = 1'b1;
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'(i);
      cyc();
      if (i == 1) begin
        n_cmp++; if (issue_v_o !== 1'b1 || issue_pkt_o !== 128'h1) begin n_err++; $display("FAIL fill_latency: got v=%b pkt=%h want v=1 pkt=1", issue_v_o, issue_pkt_o); end
      end
    end
    idle();
    n_cmp++; if (fe_queue_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", fe_queue_ready_o); end
    n_cmp++; if (occupancy_o !== 4'd8) begin n_err++; $display("FAIL fill_occ: got %0d want 8", occupancy_o); end
    n_cmp++; if (issue_pkt_o !== 128'h1) begin n_err++; $display("FAIL fill_head: got %h want 1", issue_pkt_o); end
  endtask

  task automatic test_replay();
    for (int i = 1; i <= 3; i++) begin
      n_cmp++; if (issue_v_o !== 1'b1 || issue_pkt_o !== 128'(i)) begin n_err++; $display("FAIL replay_issue%0d: got v=%b pkt=%h want v=1 pkt=%0h", i, issue_v_o, issue_pkt_o, i); end
      issue_yumi_i = 1'b1;
      cyc();
    end
    idle();
    commit_i = 1'b1;
    n_cmp++; if (fe_queue_ready_o !== 1'b0) begin n_err++; $display("FAIL replay_ready_same: got %b want 0", fe_queue_ready_o); end
    cyc();
    idle();
    n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL replay_ready_next: got %b want 1", fe_queue_ready_o); end
    n_cmp++; if (occupancy_o !== 4'd7) begin n_err++; $display("FAIL replay_occ: got %0d want 7", occupancy_o); end
    roll_i = 1'b1;
    issue_yumi_i = 1'b1;
    cyc();
    idle();
    for (int i = 2; i <= 4; i++) begin
      n_cmp++; if (issue_v_o !== 1'b1 || issue_pkt_o !== 128'(i)) begin n_err++; $display("FAIL replay_re%0d: got v=%b pkt=%h want v=1 pkt=%0h", i, issue_v_o, issue_pkt_o, i); end
      issue_yumi_i = (i != 4);
      if (i != 4) cyc();
    end
    idle();
    n_cmp++; if (occupancy_o !== 4'd7) begin n_err++; $display("FAIL replay_occ_after: got %0d want 7", occupancy_o); end
  endtask

  task automatic test_clear();
    fe_queue_v_i = 1'b1;
    fe_queue_i   = 128'h9;
    clr_i        = 1'b1;
    commit_i     = 1'b1;
    n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL clear_ready_pre: got %b want 1", fe_queue_ready_o); end
    cyc();
    idle();
    n_cmp++; if (issue_v_o !== 1'b0) begin n_err++; $display("FAIL clear_issue_v: got %b want 0", issue_v_o); end
    n_cmp++; if (occupancy_o !== 4'd0) begin n_err++; $display("FAIL clear_occ: got %0d want 0", occupancy_o); end
    fe_queue_v_i = 1'b1;
    fe_queue_i   = 128'hD;
    cyc();
    idle();
    n_cmp++; if (issue_v_o !== 1'b1 || issue_pkt_o !== 128'hD) begin n_err++; $display("FAIL clear_next_pkt: got v=%b pkt=%h want v=1 pkt=d", issue_v_o, issue_pkt_o); end
    n_cmp++; if (occupancy_o !== 4'd1) begin n_err++; $display("FAIL clear_next_occ: got %0d want 1", occupancy_o); end
    clr_i = 1'b1;
    cyc();
    idle();
    n_cmp++; if (occupancy_o !== 4'd0 || issue_v_o !== 1'b0) begin n_err++; $display("FAIL clear_empty: got occ=%0d v=%b want occ=0 v=0", occupancy_o, issue_v_o); end
  endtask

  task automatic test_full_commit();
    for (int i = 0; i < 8; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'(8'h10 + i);
      cyc();
    end
    idle();
    n_cmp++; if (fe_queue_ready_o !== 1'b0) begin n_err++; $display("FAIL fullc_ready_full: got %b want 0", fe_queue_ready_o); end
    issue_yumi_i = 1'b1;
    cyc();
    idle();
    commit_i     = 1'b1;
    fe_queue_v_i = 1'b1;
    fe_queue_i   = 128'h20;
    n_cmp++; if (fe_queue_ready_o !== 1'b0) begin n_err++; $display("FAIL fullc_refused: got ready=%b want 0", fe_queue_ready_o); end
    cyc();
    commit_i = 1'b0;
    n_cmp++; if (fe_queue_ready_o !== 1'b1 || occupancy_o !== 4'd7) begin n_err++; $display("FAIL fullc_freed: got ready=%b occ=%0d want ready=1 occ=7", fe_queue_ready_o, occupancy_o); end
    cyc();
    idle();
    n_cmp++; if (fe_queue_ready_o !== 1'b0 || occupancy_o !== 4'd8) begin n_err++; $display("FAIL fullc_accepted: got ready=%b occ=%0d want ready=0 occ=8", fe_queue_ready_o, occupancy_o); end
    for (int i = 1; i <= 8; i++) begin
      logic [127:0] exp;
      exp = (i == 8) ? 128'h20 : 128'(8'h10 + i);
      n_cmp++; if (issue_v_o !== 1'b1 || issue_pkt_o !== exp) begin n_err++; $display("FAIL fullc_drain%0d: got v=%b pkt=%h want v=1 pkt=%h", i, issue_v_o, issue_pkt_o, exp); end
      issue_yumi_i = 1'b1;
      cyc();
    end
    idle();
    n_cmp++; if (issue_v_o !== 1'b0) begin n_err++; $display("FAIL fullc_drained_v: got %b want 0", issue_v_o); end
    clr_i = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_cmd();
    cmd_v_i = 1'b1;
    cmd_i   = 128'hA;
    cyc();
    n_cmp++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== 128'hA) begin n_err++; $display("FAIL cmd_latency: got v=%b cmd=%h want v=1 cmd=a", fe_cmd_v_o, fe_cmd_o); end
    cmd_i = 128'hB;
    cyc();
    idle();
    n_cmp++; if (cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL cmd_full: got ready=%b want 0", cmd_ready_o); end
    fe_cmd_yumi_i = 1'b1;
    cyc();
    idle();
    n_cmp++; if (cmd_ready_o !== 1'b1 || fe_cmd_o !== 128'hB) begin n_err++; $display("FAIL cmd_pop1: got ready=%b cmd=%h want ready=1 cmd=b", cmd_ready_o, fe_cmd_o); end
    cmd_v_i = 1'b1;
    cmd_i   = 128'hC;
    clr_i   = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      logic [127:0] exp;
      exp = (i == 0) ? 128'hB : 128'hC;
      n_cmp++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== exp) begin n_err++; $display("FAIL cmd_order%0d: got v=%b cmd=%h want v=1 cmd=%h", i, fe_cmd_v_o, fe_cmd_o, exp); end
      fe_cmd_yumi_i = 1'b1;
      cyc();
    end
    idle();
    n_cmp++; if (fe_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL cmd_empty: got v=%b want 0", fe_cmd_v_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      fe_queue_v_i = 1'b1;
      fe_queue_i   = 128'(8'h30 + i);
      cmd_v_i      = (i == 0);
      cmd_i        = 128'hE;
      cyc();
    end
    idle();
    n_cmp++; if (occupancy_o !== 4'd5 || fe_cmd_v_o !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got occ=%0d cmd_v=%b want occ=5 cmd_v=1", occupancy_o, fe_cmd_v_o); end
    #3;
    reset_n_i = 1'b0;
    #1;
    n_cmp++; if (issue_v_o !== 1'b0 || fe_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL rmid_valids: got issue_v=%b cmd_v=%b want 0 0", issue_v_o, fe_cmd_v_o); end
    n_cmp++; if (occupancy_o !== 4'd0 || fe_queue_ready_o !== 1'b1 || cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_state: got occ=%0d ready=%b cmd_ready=%b want 0 1 1", occupancy_o, fe_queue_ready_o, cmd_ready_o); end
    cyc();
    #2;
    reset_n_i = 1'b1;
    cyc();
    fe_queue_v_i = 1'b1;
    fe_queue_i   = 128'h40;
    cmd_v_i      = 1'b1;
    cmd_i        = 128'hF;
    cyc();
    idle();
    n_cmp++; if (issue_v_o !== 1'b1 || issue_pkt_o !== 128'h40 || occupancy_o !== 4'd1) begin n_err++; $display("FAIL rmid_restart: got v=%b pkt=%h occ=%0d want v=1 pkt=40 occ=1", issue_v_o, issue_pkt_o, occupancy_o); end
    n_cmp++; if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== 128'hF || cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_cmd: got v=%b cmd=%h ready=%b want v=1 cmd=f ready=1", fe_cmd_v_o, fe_cmd_o, cmd_ready_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_replay();
    test_clear();
    test_full_commit();
    test_cmd();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
